instr_register_exec: RTL and testbench

INSTR_REGISTER_EXEC -- requirements
Module: instr_register_exec

---
 rtl/instr_register_pkg.sv | 38 +++
 rtl/instr_register_exec_alu.sv | 50 +++++
 rtl/instr_register_exec.sv | 113 +++++++++++
 tb/tb_instr_register_exec.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register stack and its ALU.
// The testbench imports this package too, so the types stay identical on both sides.
package instr_register_pkg;

    typedef logic [4:0]          address_t;
    typedef logic signed [31:0]  operand_t;
    typedef logic signed [63:0]  result_t;

    localparam int STACK_DEPTH = 2 ** $bits(address_t);

    // Codes 8-15 are named so that every 4-bit value is a legal member of the enum.
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7,
        RSV8  = 4'd8,
        RSV9  = 4'd9,
        RSV10 = 4'd10,
        RSV11 = 4'd11,
        RSV12 = 4'd12,
        RSV13 = 4'd13,
        RSV14 = 4'd14,
        RSV15 = 4'd15
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rezultat;
    } instruction_t;

endpackage

// File: rtl/instr_register_exec_alu.sv
// Combinational 64-bit signed ALU for the instruction register stack.
// Divide and modulo by zero return 0 and raise div0.
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  opc,
    input  operand_t op_a,
    input  operand_t op_b,
    output result_t  rezultat,
    output logic     div0
);

    result_t w_a;
    result_t w_b;
    logic    w_bZero;

    assign w_a     = {{32{op_a[31]}}, op_a};
    assign w_b     = {{32{op_b[31]}}, op_b};
    assign w_bZero = (op_b == '0);

    // SystemVerilog signed / and % already truncate toward zero and follow the dividend sign.
    always_comb begin
        rezultat = '0;
        div0     = 1'b0;
        case (opc)
            ZERO:  rezultat = '0;
            PASSA: rezultat = w_a;
            PASSB: rezultat = w_b;
            ADD:   rezultat = w_a + w_b;
            SUB:   rezultat = w_a - w_b;
            MULT:  rezultat = w_a * w_b;
            DIV: begin
                if (w_bZero) begin
                    div0 = 1'b1;
                end else begin
                    rezultat = w_a / w_b;
                end
            end
            MOD: begin
                if (w_bZero) begin
                    div0 = 1'b1;
                end else begin
                    rezultat = w_a % w_b;
                end
            end
            default: rezultat = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_exec.sv
// Instruction register stack with a two-stage write: operands land first, the
// ALU result is committed one edge later unless the same entry is rewritten.
module instr_register_exec
    import instr_register_pkg::*;
#(
    parameter int NUM_ENTRIES = 32
)
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_en,
    input  address_t     write_pointer,
    input  opcode_t      opcode,
    input  operand_t     operand_a,
    input  operand_t     operand_b,
    input  address_t     read_pointer,
    output instruction_t instruction_word,
    output logic         result_valid,
    output logic         div0_err,
    output logic [15:0]  done_count
);

    logic     r_s2Valid;
    address_t r_s2Addr;
    opcode_t  r_s2Opc;
    operand_t r_s2OpA;
    operand_t r_s2OpB;

    result_t  w_aluResult;
    logic     w_aluDiv0;
    logic     w_collide;
    logic     w_commit;

    logic        r_div0Err;
    logic [15:0] r_doneCount;

    instruction_t [NUM_ENTRIES-1:0] w_entries;
    logic         [NUM_ENTRIES-1:0] w_valids;

    instr_alu u_alu (
        .opc      (r_s2Opc),
        .op_a     (r_s2OpA),
        .op_b     (r_s2OpB),
        .rezultat (w_aluResult),
        .div0     (w_aluDiv0)
    );

    // A fresh write to the pending entry supersedes its result, so nothing is committed.
    assign w_collide = load_en && (write_pointer == r_s2Addr);
    assign w_commit  = r_s2Valid && !w_collide;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2Valid <= 1'b0;
            r_s2Addr  <= '0;
            r_s2Opc   <= ZERO;
            r_s2OpA   <= '0;
            r_s2OpB   <= '0;
        end else begin
            r_s2Valid <= load_en;
            if (load_en) begin
                r_s2Addr <= write_pointer;
                r_s2Opc  <= opcode;
                r_s2OpA  <= operand_a;
                r_s2OpB  <= operand_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div0Err   <= 1'b0;
            r_doneCount <= '0;
        end else begin
            r_div0Err <= w_commit && w_aluDiv0;
            if (w_commit) begin
                r_doneCount <= r_doneCount + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        instruction_t r_entry;
        logic         r_valid;
        logic         w_wrHit;
        logic         w_commitHit;

        assign w_wrHit     = load_en && (write_pointer == address_t'(i));
        assign w_commitHit = w_commit && (r_s2Addr == address_t'(i));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_entry <= '{opc: ZERO, op_a: '0, op_b: '0, rezultat: '0};
                r_valid <= 1'b0;
            end else if (w_wrHit) begin
                r_entry <= '{opc: opcode, op_a: operand_a, op_b: operand_b, rezultat: '0};
                r_valid <= 1'b0;
            end else if (w_commitHit) begin
                r_entry.rezultat <= w_aluResult;
                r_valid          <= 1'b1;
            end
        end

        assign w_entries[i] = r_entry;
        assign w_valids[i]  = r_valid;
    end

    assign instruction_word = w_entries[read_pointer];
    assign result_valid     = w_valids[read_pointer];
    assign div0_err         = r_div0Err;
    assign done_count       = r_doneCount;

endmodule

// File: tb/tb_instr_register_exec.sv
// Randomised and directed checks of instr_register_exec against a
// result-at-write-time reference model of the register stack.
`timescale 1ns/10ps
module tb_instr_register_exec;
    import instr_register_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         load_en;
    address_t     write_pointer;
    opcode_t      opcode;
    operand_t     operand_a;
    operand_t     operand_b;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         result_valid;
    logic         div0_err;
    logic [15:0]  done_count;

    int testCount = 0;
    int failCount = 0;

    opcode_t     mOpc   [32];
    operand_t    mA     [32];
    operand_t    mB     [32];
    result_t     mRes   [32];
    bit          mValid [32];
    logic [15:0] mDone;
    bit          mDiv0;
    bit          pendValid;
    address_t    pendAddr;
    result_t     pendRes;
    bit          pendDiv0;

    instr_register_exec #(.NUM_ENTRIES(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result_valid     (result_valid),
        .div0_err         (div0_err),
        .done_count       (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected result straight from the opcode table, using 64-bit integer arithmetic.
    function automatic result_t refResult(opcode_t op, operand_t a, operand_t b);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        case (op)
            PASSA:   return sa;
            PASSB:   return sb;
            ADD:     return sa + sb;
            SUB:     return sa - sb;
            MULT:    return sa * sb;
            DIV:     return (sb == 0) ? 64'sd0 : sa / sb;
            MOD:     return (sb == 0) ? 64'sd0 : sa % sb;
            default: return 64'sd0;
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mOpc[i]   = ZERO;
            mA[i]     = '0;
            mB[i]     = '0;
            mRes[i]   = '0;
            mValid[i] = 1'b0;
        end
        mDone     = '0;
        mDiv0     = 1'b0;
        pendValid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [135:0] got, input logic [135:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check counters after.
    task automatic applyStimulus(input logic ld, input address_t wp, input opcode_t op,
                                 input operand_t a, input operand_t b);
        @(negedge clk);
        load_en       = ld;
        write_pointer = wp;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        @(posedge clk);
        mDiv0 = 1'b0;
        if (pendValid && !(ld && wp == pendAddr)) begin
            mRes[pendAddr]   = pendRes;
            mValid[pendAddr] = 1'b1;
            mDone            = mDone + 16'd1;
            mDiv0            = pendDiv0;
        end
        pendValid = ld;
        if (ld) begin
            mOpc[wp]   = op;
            mA[wp]     = a;
            mB[wp]     = b;
            mRes[wp]   = '0;
            mValid[wp] = 1'b0;
            pendAddr   = wp;
            pendRes    = refResult(op, a, b);
            pendDiv0   = (op == DIV || op == MOD) && (b == 0);
        end
        #1;
        checkOutput("done_count", done_count, mDone);
        checkOutput("div0_err", div0_err, mDiv0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 5'd0, ZERO, 32'sd0, 32'sd0);
    endtask

    task automatic checkEntry(input string tag, input int addr);
        instruction_t exp;
        address_t     ad;
        ad           = address_t'(addr);
        read_pointer = ad;
        #0.1;
        exp.opc      = mOpc[ad];
        exp.op_a     = mA[ad];
        exp.op_b     = mB[ad];
        exp.rezultat = mRes[ad];
        checkOutput(tag, instruction_word, exp);
        checkOutput({tag, "_valid"}, result_valid, mValid[ad]);
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < 32; i++) begin
            checkEntry($sformatf("%s_%0d", tag, i), i);
        end
    endtask

    initial begin
        logic [15:0] doneBefore;
        address_t    wp;
        address_t    lastWp;
        opcode_t     op;
        operand_t    a;
        operand_t    b;

        reset_n       = 1'b0;
        load_en       = 1'b0;
        write_pointer = '0;
        opcode        = ZERO;
        operand_a     = '0;
        operand_b     = '0;
        read_pointer  = '0;
        modelReset();

        #2;
        checkOutput("rst_done", done_count, 16'd0);
        checkOutput("rst_div0", div0_err, 1'b0);
        #20;
        reset_n = 1'b1;
        idleCycle();
        checkAll("rst0");

        // ADD latency: operands visible after edge N, result after edge N+1
        applyStimulus(1'b1, 5'd5, ADD, 32'sd7, -32'sd3);
        checkEntry("add_n", 5);
        checkOutput("add_n_rez", $unsigned(instruction_word.rezultat), 64'd0);
        checkOutput("add_n_valid", result_valid, 1'b0);
        idleCycle();
        checkEntry("add_n1", 5);
        checkOutput("add_n1_rez", $unsigned(instruction_word.rezultat), 64'd4);
        checkOutput("add_n1_valid", result_valid, 1'b1);
        checkOutput("add_n1_done", done_count, 16'd1);

        applyStimulus(1'b1, 5'd6, MULT, 32'sh7FFFFFFF, 32'sd2);
        idleCycle();
        checkEntry("mult", 6);
        checkOutput("mult_rez", $unsigned(instruction_word.rezultat), 64'h00000000FFFFFFFE);

        // Back-to-back DIV, MOD, then divide by zero
        applyStimulus(1'b1, 5'd7, DIV, -32'sd7, 32'sd2);
        applyStimulus(1'b1, 5'd8, MOD, -32'sd7, 32'sd2);
        applyStimulus(1'b1, 5'd9, DIV, 32'sd9, 32'sd0);
        checkOutput("div0_before", div0_err, 1'b0);
        idleCycle();
        checkOutput("div0_pulse", div0_err, 1'b1);
        checkEntry("div", 7);
        checkOutput("div_rez", $unsigned(instruction_word.rezultat), 64'hFFFFFFFFFFFFFFFD);
        checkEntry("mod", 8);
        checkOutput("mod_rez", $unsigned(instruction_word.rezultat), 64'hFFFFFFFFFFFFFFFF);
        checkEntry("div0", 9);
        checkOutput("div0_rez", $unsigned(instruction_word.rezultat), 64'd0);
        checkOutput("div0_valid", result_valid, 1'b1);
        idleCycle();
        checkOutput("div0_drop", div0_err, 1'b0);

        // Same-address collision: the second write wins and only one result counts
        doneBefore = mDone;
        applyStimulus(1'b1, 5'd3, ADD, 32'sd1, 32'sd1);
        applyStimulus(1'b1, 5'd3, SUB, 32'sd10, 32'sd4);
        idleCycle();
        checkEntry("coll", 3);
        checkOutput("coll_opc", instruction_word.opc, SUB);
        checkOutput("coll_rez", $unsigned(instruction_word.rezultat), 64'd6);
        checkOutput("coll_done", done_count, doneBefore + 16'd1);

        // Mid-stream reset with a result still pending
        applyStimulus(1'b1, 5'd12, ADD, 32'sd5, 32'sd5);
        reset_n = 1'b0;
        load_en = 1'b0;
        modelReset();
        #1;
        checkOutput("mid_rst_done", done_count, 16'd0);
        checkOutput("mid_rst_div0", div0_err, 1'b0);
        reset_n = 1'b1;
        idleCycle();
        checkAll("mid_rst");

        // First edge after reset accepts a write
        applyStimulus(1'b1, 5'd31, PASSB, 32'sd11, -32'sd2);
        idleCycle();
        checkEntry("first_wr", 31);

        // Random regression with occasional address reuse and zero divisors
        lastWp = '0;
        for (int n = 0; n < 20; n++) begin
            if (n > 0 && $urandom_range(0, 3) == 0) begin
                wp = lastWp;
            end else begin
                wp = address_t'($urandom_range(0, 31));
            end
            op = opcode_t'(4'($urandom_range(0, 15)));
            a  = operand_t'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                b = '0;
            end else begin
                b = operand_t'($urandom) >>> $urandom_range(0, 28);
            end
            applyStimulus(1'b1, wp, op, a, b);
            lastWp = wp;
        end
        idleCycle();
        checkAll("rnd");
        idleCycle();
        for (int k = 0; k < 10; k++) begin
            checkEntry($sformatf("rnd_rd%0d", k), int'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
